// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: multiplier FSM states, iteration
// constants and the carry helper used by the sequential multiplier.
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_t;

  localparam int MUL_ITERS = 32;
  localparam int MUL_CNT_W = 5;
  localparam logic [MUL_CNT_W-1:0] MUL_LAST = MUL_CNT_W'(MUL_ITERS - 1);

  // Carry out of a wrapping 32-bit add: the sum is smaller than an operand.
  function automatic logic carry_out(input logic [31:0] sum,
                                     input logic [31:0] opa);
    return (sum < opa);
  endfunction

endpackage

// File: rtl/adder.sv
// Shared 32-bit combinational adder; the carry is not exported.
module adder (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] out
);

  assign out = a + b;

endmodule

// File: rtl/multu_seq.sv
// Sequential 32x32 unsigned shift-and-add multiplier for MULTU; the product
// is built in {hi,lo} over 32 iterations through one shared adder.
module multu_seq
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  mul_state_t           state;
  mul_state_t           state_nx;
  logic [MUL_CNT_W-1:0] count;
  logic [31:0]          mcand;
  logic [31:0]          sum;
  logic                 carry;
  logic                 accept;
  logic                 last_iter;

  adder u_adder (
    .a  (hi),
    .b  (mcand),
    .out(sum)
  );

  assign carry     = carry_out(sum, hi);
  assign accept    = start && ((state == IDLE) || (state == DONE));
  assign last_iter = (state == RUN) && (count == MUL_LAST);
  assign busy      = (state == RUN);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (count == MUL_LAST) state_nx = DONE;
      DONE:    state_nx = start ? RUN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: operand capture on accept, one shift-and-add step per RUN edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      mcand <= '0;
      hi    <= '0;
      lo    <= '0;
      done  <= 1'b0;
    end else begin
      done <= last_iter;
      if (accept) begin
        mcand <= a;
        lo    <= b;
        hi    <= '0;
        count <= '0;
      end else if (state == RUN) begin
        if (lo[0]) begin
          hi <= {carry, sum[31:1]};
          lo <= {sum[0], lo[31:1]};
        end else begin
          hi <= {1'b0, hi[31:1]};
          lo <= {hi[0], lo[31:1]};
        end
        count <= count + MUL_CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_multu_seq.sv
// Scoreboard bench for multu_seq: directed corner cases plus random operands
// checked against a plain 64-bit multiply reference.
module tb_multu_seq;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  typedef struct {
    logic [63:0] prod;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [63:0] last_prod = '0;

  multu_seq dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .a    (a),
    .b    (b),
    .busy (busy),
    .done (done),
    .hi   (hi),
    .lo   (lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
    logic [63:0] xx, yy;
    xx = {32'd0, x};
    yy = {32'd0, y};
    return xx * yy;
  endfunction

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%016h, expected 0x%016h", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (done) begin
      checks++;
      if (busy) begin
        errors++;
        $display("FAIL busy_with_done: busy=%0b done=%0b, expected busy=0", busy, done);
      end
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: done=1 at cycle %0d, expected no pulse", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check64("product", {hi, lo}, e.prod);
        checks++;
        if (cyc - e.acc != 32) begin
          errors++;
          $display("FAIL latency: done %0d edges after accept, expected 32", cyc - e.acc);
        end
        last_prod = e.prod;
      end
    end
  end

  // Assumes the caller is #1 after a posedge; leaves the bench #1 after the accepting edge.
  task automatic issue(input logic [31:0] x, input logic [31:0] y, output int acc);
    exp_t e;
    int   guard;
    guard = 0;
    while (busy && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    a = x;
    b = y;
    start = 1'b1;
    acc = cyc + 1;
    e.prod = ref_mul(x, y);
    e.acc  = acc;
    sb.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    a = $urandom;
    b = $urandom;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL timeout: %0d results outstanding, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int acc;
    logic [31:0] ra, rb;

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check64("reset_hilo", {hi, lo}, 64'd0);
    check64("reset_flags", {62'd0, busy, done}, 64'd0);

    issue(32'd3, 32'd5, acc);
    check64("busy_after_accept", {63'd0, busy}, 64'd1);
    drain();
    repeat (3) @(posedge clk);
    #1;
    check64("hold_after_done", {hi, lo}, last_prod);
    check64("idle_flags", {62'd0, busy, done}, 64'd0);

    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, acc); drain();
    issue(32'h8000_0000, 32'd2, acc);         drain();
    issue(32'd0, 32'h1234_5678, acc);         drain();
    issue(32'h1234_5678, 32'd0, acc);         drain();
    issue(32'd1, 32'hFFFF_FFFF, acc);         drain();

    // Start pulse mid-run must be ignored.
    issue(32'd7, 32'd6, acc);
    wait_until(acc + 10);
    a = 32'd9;
    b = 32'd9;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    drain();
    repeat (40) @(posedge clk);
    #1;
    check64("ignored_start_lo", {32'd0, lo}, 64'd42);

    // Reset during RUN aborts the operation.
    issue(32'h1234_5678, 32'h9ABC_DEF0, acc);
    wait_until(acc + 12);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    sb.delete();
    check64("abort_hilo", {hi, lo}, 64'd0);
    check64("abort_flags", {62'd0, busy, done}, 64'd0);
    check64("abort_state", {62'd0, dut.state}, {62'd0, IDLE});
    issue(32'h0001_0000, 32'h0001_0000, acc); drain();

    // Back-to-back: second request asserted during the DONE cycle.
    issue(32'h0000_DEAD, 32'h0000_BEEF, acc);
    begin
      int guard;
      exp_t e;
      guard = 0;
      @(negedge clk);
      while (!done && guard < 60) begin
        @(negedge clk);
        guard++;
      end
      a = 32'd2;
      b = 32'd3;
      start = 1'b1;
      e.prod = ref_mul(32'd2, 32'd3);
      e.acc  = cyc + 1;
      sb.push_back(e);
      @(posedge clk); #1;
      start = 1'b0;
      check64("b2b_accepted", {63'd0, busy}, 64'd1);
    end
    drain();

    for (int i = 0; i < 20; i++) begin
      ra = $urandom;
      rb = $urandom;
      case (i % 4)
        0: ra = ra & 32'h0000_FFFF;
        1: rb = rb | 32'h8000_0001;
        default: ;
      endcase
      issue(ra, rb, acc);
      if (i % 3 == 0) drain();
    end
    drain();

    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "timeout");
  end

endmodule
